// File: rtl/regfile_write_arbiter_if.sv
// Write-port bundle between the ALU/LSU result sources and the register file write arbiter.
// The master side drives the results, and the slave side (the arbiter) drives the register file port and the status signals.
interface regfile_write_arbiter_if #(
  parameter int DEPTH = 4
) ();
  localparam int AW = $clog2(DEPTH);

  logic          alu_valid;
  logic [4:0]    alu_rd;
  logic [31:0]   alu_data;
  logic          lsu_valid;
  logic          lsu_ready;
  logic [4:0]    lsu_rd;
  logic [31:0]   lsu_data;
  logic          we3;
  logic [4:0]    a3;
  logic [31:0]   wd3;
  logic [31:0]   pending;
  logic [AW:0]   level;

  modport master (
    output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
    input  lsu_ready, we3, a3, wd3, pending, level
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
    output lsu_ready, we3, a3, wd3, pending, level
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Sole driver of the register file write port: the ALU writes with 1-cycle latency, and loads are queued and written at least 2 cycles after the push.
// The ALU always wins the port. LSU backpressure comes from the registered FIFO level, and a younger ALU write kills queued writes to the same register.
module regfile_write_arbiter #(
  parameter int DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  regfile_write_arbiter_if.slave bus
);
  localparam int          AW   = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [4:0]       rd_q   [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [DEPTH-1:0] live_q, live_d;
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      level_q, level_d;
  logic             we3_q, we3_d;
  logic [4:0]       a3_q, a3_d;
  logic [31:0]      wd3_q, wd3_d;

  logic alu_eff, push, head_vld, head_live, pop, drain;

  always_comb begin
    alu_eff   = bus.alu_valid && (bus.alu_rd != 5'd0);
    // A same-register push alongside an ALU write is older and already superseded.
    push      = bus.lsu_valid && (level_q != FULL) && (bus.lsu_rd != 5'd0)
                && !(alu_eff && (bus.lsu_rd == bus.alu_rd));
    head_vld  = (level_q != '0);
    head_live = live_q[rptr_q];
    drain     = head_vld && head_live && !alu_eff;
    pop       = head_vld && (!head_live || !alu_eff);

    we3_d = alu_eff || drain;
    a3_d  = a3_q;
    wd3_d = wd3_q;
    if (alu_eff) begin
      a3_d  = bus.alu_rd;
      wd3_d = bus.alu_data;
    end else if (drain) begin
      a3_d  = rd_q[rptr_q];
      wd3_d = data_q[rptr_q];
    end

    live_d = live_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (alu_eff && (rd_q[i] == bus.alu_rd)) live_d[i] = 1'b0;
    end
    if (pop)  live_d[rptr_q] = 1'b0;
    if (push) live_d[wptr_q] = 1'b1;

    level_d = level_q + (AW+1)'(push) - (AW+1)'(pop);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i]   <= '0;
        data_q[i] <= '0;
      end
      live_q  <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      we3_q   <= 1'b0;
      a3_q    <= '0;
      wd3_q   <= '0;
    end else begin
      if (push) begin
        rd_q[wptr_q]   <= bus.lsu_rd;
        data_q[wptr_q] <= bus.lsu_data;
        wptr_q         <= wptr_q + AW'(1);
      end
      if (pop) rptr_q <= rptr_q + AW'(1);
      live_q  <= live_d;
      level_q <= level_d;
      we3_q   <= we3_d;
      a3_q    <= a3_d;
      wd3_q   <= wd3_d;
    end
  end

  // Popped entries are always cleared, so only occupied slots can carry a live bit.
  always_comb begin
    bus.pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (live_q[i]) bus.pending[rd_q[i]] = 1'b1;
    end
    bus.pending[0] = 1'b0;
  end

  assign bus.lsu_ready = (level_q != FULL);
  assign bus.level     = level_q;
  assign bus.we3       = we3_q;
  assign bus.a3        = a3_q;
  assign bus.wd3       = wd3_q;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed scenarios checked against constants, and a randomized run checked against a queue-based model of the write-port rules.
module tb_regfile_write_arbiter;
  localparam int DEPTH = 4;
  localparam int AW    = $clog2(DEPTH);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   pass = 0;
  int   tot  = 0;

  regfile_write_arbiter_if #(.DEPTH(DEPTH)) dif ();
  regfile_write_arbiter #(.DEPTH(DEPTH)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(dif));

  always #5 clk = ~clk;

  typedef struct packed { logic [4:0] rd; logic [31:0] data; logic live; } ent_t;
  ent_t        q[$];
  ent_t        e;
  bit          m_alu_w, m_rdy;
  bit          m_acc = 1'b0;
  logic        m_we3 = 1'b0;
  logic [4:0]  m_a3  = '0;
  logic [31:0] m_wd3 = '0;
  logic [31:0] m_pending = '0;
  logic [AW:0] m_level = '0;

  // Model: an ordered list of queued loads, each carrying a live flag.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_acc = 1'b0; m_we3 = 1'b0; m_a3 = '0; m_wd3 = '0;
    end else begin
      m_alu_w = dif.alu_valid && (dif.alu_rd != 5'd0);
      m_rdy   = (q.size() < DEPTH);
      m_acc   = dif.lsu_valid && m_rdy;
      m_we3   = 1'b0;
      if (m_alu_w) begin m_we3 = 1'b1; m_a3 = dif.alu_rd; m_wd3 = dif.alu_data; end
      if (q.size() > 0) begin
        if (!q[0].live) void'(q.pop_front());
        else if (!m_alu_w) begin
          m_we3 = 1'b1; m_a3 = q[0].rd; m_wd3 = q[0].data;
          void'(q.pop_front());
        end
      end
      if (m_alu_w) foreach (q[i]) if (q[i].rd == dif.alu_rd) q[i].live = 1'b0;
      if (m_acc && dif.lsu_rd != 5'd0 && !(m_alu_w && dif.lsu_rd == dif.alu_rd)) begin
        e.rd = dif.lsu_rd; e.data = dif.lsu_data; e.live = 1'b1;
        q.push_back(e);
      end
    end
    m_level   = (AW+1)'(q.size());
    m_pending = '0;
    foreach (q[i]) if (q[i].live) m_pending[q[i].rd] = 1'b1;
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic drive(input bit av, input logic [4:0] ard, input logic [31:0] ad,
                       input bit lv, input logic [4:0] lrd, input logic [31:0] ld);
    dif.alu_valid = av; dif.alu_rd = ard; dif.alu_data = ad;
    dif.lsu_valid = lv; dif.lsu_rd = lrd; dif.lsu_data = ld;
  endtask

  task automatic test_reset_and_alu();
    drive(0, 0, 0, 0, 0, 0);
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();
    tot++; if (dif.we3 !== 1'b0) $display("FAIL reset_we3 got %0b exp 0", dif.we3); else pass++;
    tot++; if (dif.level !== 3'd0) $display("FAIL reset_level got %0d exp 0", dif.level); else pass++;
    tot++; if (dif.lsu_ready !== 1'b1) $display("FAIL reset_ready got %0b exp 1", dif.lsu_ready); else pass++;
    tot++; if (dif.pending !== 32'd0) $display("FAIL reset_pending got %h exp 0", dif.pending); else pass++;
    drive(1, 5, 32'hDEADBEEF, 0, 0, 0);
    cyc();
    drive(0, 0, 0, 0, 0, 0);
    tot++; if ({dif.we3, dif.a3, dif.wd3} !== {1'b1, 5'd5, 32'hDEADBEEF})
      $display("FAIL alu_write got we=%0b a=%0d d=%h exp 1/5/deadbeef", dif.we3, dif.a3, dif.wd3); else pass++;
    cyc();
    tot++; if (dif.we3 !== 1'b0) $display("FAIL alu_we3_drop got %0b exp 0", dif.we3); else pass++;
  endtask

  task automatic test_lsu_path();
    drive(0, 0, 0, 1, 7, 32'h11);
    cyc();
    drive(0, 0, 0, 0, 0, 0);
    tot++; if (dif.pending !== 32'h80) $display("FAIL lsu_pending got %h exp 80", dif.pending); else pass++;
    tot++; if (dif.we3 !== 1'b0) $display("FAIL lsu_early_we3 got %0b exp 0", dif.we3); else pass++;
    cyc();
    tot++; if ({dif.we3, dif.a3, dif.wd3} !== {1'b1, 5'd7, 32'h11})
      $display("FAIL lsu_write got we=%0b a=%0d d=%h exp 1/7/11", dif.we3, dif.a3, dif.wd3); else pass++;
    tot++; if (dif.pending !== 32'd0) $display("FAIL lsu_pending_clr got %h exp 0", dif.pending); else pass++;
    cyc();
  endtask

  task automatic test_alu_priority();
    drive(0, 0, 0, 1, 3, 32'h33);
    cyc();
    drive(1, 4, 32'h40, 0, 0, 0);
    cyc();
    for (int k = 0; k < 3; k++) begin
      tot++; if ({dif.we3, dif.a3, dif.wd3} !== {1'b1, 5'd4, 32'h40 + 32'(k)})
        $display("FAIL prio_alu%0d got we=%0b a=%0d d=%h exp a=4", k, dif.we3, dif.a3, dif.wd3); else pass++;
      tot++; if (dif.level !== 3'd1) $display("FAIL prio_level%0d got %0d exp 1", k, dif.level); else pass++;
      if (k < 1) drive(1, 4, 32'h41, 0, 0, 0);
      else if (k < 2) drive(1, 4, 32'h42, 0, 0, 0);
      else drive(0, 0, 0, 0, 0, 0);
      cyc();
    end
    tot++; if ({dif.we3, dif.a3, dif.wd3} !== {1'b1, 5'd3, 32'h33})
      $display("FAIL prio_load got we=%0b a=%0d d=%h exp 1/3/33", dif.we3, dif.a3, dif.wd3); else pass++;
    tot++; if (dif.level !== 3'd0) $display("FAIL prio_level_end got %0d exp 0", dif.level); else pass++;
    cyc();
  endtask

  task automatic test_waw_kill();
    drive(0, 0, 0, 1, 9, 32'hAA);
    cyc();
    drive(1, 9, 32'hBB, 0, 0, 0);
    tot++; if (dif.pending !== 32'h200) $display("FAIL waw_pending_set got %h exp 200", dif.pending); else pass++;
    cyc();
    drive(0, 0, 0, 0, 0, 0);
    tot++; if ({dif.we3, dif.a3, dif.wd3} !== {1'b1, 5'd9, 32'hBB})
      $display("FAIL waw_alu got we=%0b a=%0d d=%h exp 1/9/bb", dif.we3, dif.a3, dif.wd3); else pass++;
    tot++; if (dif.pending !== 32'd0) $display("FAIL waw_pending_clr got %h exp 0", dif.pending); else pass++;
    tot++; if (dif.level !== 3'd1) $display("FAIL waw_dead_level got %0d exp 1", dif.level); else pass++;
    cyc();
    tot++; if (dif.we3 !== 1'b0) $display("FAIL waw_dead_pop_we3 got %0b exp 0", dif.we3); else pass++;
    tot++; if (dif.level !== 3'd0) $display("FAIL waw_dead_pop_level got %0d exp 0", dif.level); else pass++;
    cyc();
  endtask

  task automatic test_full_backpressure();
    logic [4:0] exp_rd [5];
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 1, 32'(i), 1, 5'(10 + i), 32'h100 + 32'(i));
      cyc();
    end
    drive(1, 1, 32'h5, 1, 20, 32'h200);
    tot++; if (dif.lsu_ready !== 1'b0) $display("FAIL full_ready got %0b exp 0", dif.lsu_ready); else pass++;
    tot++; if (dif.level !== 3'd4) $display("FAIL full_level got %0d exp 4", dif.level); else pass++;
    cyc();
    tot++; if (dif.level !== 3'd4) $display("FAIL full_hold_level got %0d exp 4", dif.level); else pass++;
    dif.alu_valid = 1'b0;
    cyc();
    tot++; if (dif.lsu_ready !== 1'b1) $display("FAIL full_ready_back got %0b exp 1", dif.lsu_ready); else pass++;
    exp_rd = '{5'd10, 5'd11, 5'd12, 5'd13, 5'd20};
    for (int i = 0; i < 5; i++) begin
      tot++; if ({dif.we3, dif.a3} !== {1'b1, exp_rd[i]})
        $display("FAIL full_drain%0d got we=%0b a=%0d exp a=%0d", i, dif.we3, dif.a3, exp_rd[i]); else pass++;
      if (i == 1) begin
        tot++; if (dif.level !== 3'd3) $display("FAIL full_pushpop_level got %0d exp 3", dif.level); else pass++;
      end
      if (i == 0) begin
        cyc();
        dif.lsu_valid = 1'b0;
      end else cyc();
    end
    tot++; if (dif.we3 !== 1'b0) $display("FAIL full_end_we3 got %0b exp 0", dif.we3); else pass++;
  endtask

  task automatic test_zero_rd_and_reset();
    for (int k = 0; k < 3; k++) begin
      drive(1, 0, 32'h1, 1, 0, 32'h2);
      cyc();
      tot++; if (dif.we3 !== 1'b0) $display("FAIL zero_we3_%0d got %0b exp 0", k, dif.we3); else pass++;
      tot++; if (dif.level !== 3'd0) $display("FAIL zero_level_%0d got %0d exp 0", k, dif.level); else pass++;
    end
    drive(1, 1, 32'h1, 1, 5, 32'h5); cyc();
    drive(1, 1, 32'h1, 1, 6, 32'h6); cyc();
    tot++; if (dif.level !== 3'd2) $display("FAIL rst_pre_level got %0d exp 2", dif.level); else pass++;
    #2 rst_n = 1'b0;
    #1;
    tot++; if (dif.level !== 3'd0) $display("FAIL rst_async_level got %0d exp 0", dif.level); else pass++;
    tot++; if (dif.pending !== 32'd0) $display("FAIL rst_async_pending got %h exp 0", dif.pending); else pass++;
    tot++; if (dif.we3 !== 1'b0) $display("FAIL rst_async_we3 got %0b exp 0", dif.we3); else pass++;
    tot++; if (dif.lsu_ready !== 1'b1) $display("FAIL rst_async_ready got %0b exp 1", dif.lsu_ready); else pass++;
    drive(0, 0, 0, 0, 0, 0);
    cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_random();
    for (int c = 0; c < 420; c++) begin
      if (c >= 400) drive(0, 0, 0, 0, 0, 0);
      else begin
        if (!(dif.lsu_valid && !m_acc)) begin
          dif.lsu_valid = ($urandom_range(0, 9) < 6);
          dif.lsu_rd    = 5'($urandom_range(0, 7));
          dif.lsu_data  = $urandom;
        end
        dif.alu_valid = ($urandom_range(0, 9) < 5);
        dif.alu_rd    = 5'($urandom_range(0, 7));
        dif.alu_data  = $urandom;
      end
      cyc();
      tot++; if (dif.we3 !== m_we3) $display("FAIL rnd_we3 c=%0d got %0b exp %0b", c, dif.we3, m_we3); else pass++;
      if (m_we3) begin
        tot++; if ({dif.a3, dif.wd3} !== {m_a3, m_wd3})
          $display("FAIL rnd_write c=%0d got a=%0d d=%h exp a=%0d d=%h", c, dif.a3, dif.wd3, m_a3, m_wd3); else pass++;
      end
      tot++; if (dif.level !== m_level) $display("FAIL rnd_level c=%0d got %0d exp %0d", c, dif.level, m_level); else pass++;
      tot++; if (dif.pending !== m_pending) $display("FAIL rnd_pending c=%0d got %h exp %h", c, dif.pending, m_pending); else pass++;
      tot++; if (dif.lsu_ready !== (m_level != (AW+1)'(DEPTH)))
        $display("FAIL rnd_ready c=%0d got %0b exp %0b", c, dif.lsu_ready, m_level != (AW+1)'(DEPTH)); else pass++;
    end
  endtask

  initial begin
    test_reset_and_alu();
    test_lsu_path();
    test_alu_priority();
    test_waw_kill();
    test_full_backpressure();
    test_zero_rd_and_reset();
    test_random();
    $display("%0d/%0d checks passed", pass, tot);
    $finish;
  end
endmodule
